if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch.sv | 144 ++++++++++++++
 tb/tb_if_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction fetch stage.
// Issues one instruction-bus request at a time from pc_q and captures the
// response into a registered decode-stage output with a one-entry skid
// buffer behind it. A redirect flushes younger work and retargets the fetch.
module if_fetch #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [PC_WIDTH-1:0] F_sel_PC_i,
    input  logic                redirect_i,
    output logic [PC_WIDTH-1:0] F_PC_o,
    output logic                instr_req_o,
    output logic [PC_WIDTH-1:0] instr_addr_o,
    input  logic                instr_addr_ok_i,
    input  logic                instr_data_ok_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                D_allowin_i,
    output logic                D_valid_o,
    output logic [PC_WIDTH-1:0] D_PC_o,
    output logic [31:0]         D_instr_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] req_pc_q;
    logic                discard_q;

    logic                skid_valid_q;
    logic [PC_WIDTH-1:0] skid_pc_q;
    logic [31:0]         skid_instr_q;

    logic                d_valid_q;
    logic [PC_WIDTH-1:0] d_pc_q;
    logic [31:0]         d_instr_q;

    logic                addr_fire;
    logic                data_fire;
    logic                capture;
    logic                out_free;
    logic                flush;

    // Handshake decode shared by the FSM and the output pipeline
    always_comb begin
        addr_fire = instr_req_o & instr_addr_ok_i;
        data_fire = (state_q == S_WAIT) & instr_data_ok_i;
        capture   = data_fire & ~discard_q & ~redirect_i;
        out_free  = ~d_valid_q | D_allowin_i;
        flush     = redirect_i & (state_q != S_IDLE);
    end

    assign F_PC_o       = pc_q + PC_WIDTH'(4);
    assign instr_req_o  = (state_q == S_REQ) & ~skid_valid_q;
    assign instr_addr_o = pc_q;

    assign D_valid_o = d_valid_q;
    assign D_PC_o    = d_pc_q;
    assign D_instr_o = d_instr_q;

    // Fetch FSM: PC, outstanding-request address and discard flag
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            req_pc_q  <= '0;
            discard_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (addr_fire) begin
                        req_pc_q  <= pc_q;
                        state_q   <= S_WAIT;
                        // An accept in the redirect cycle belongs to the old path
                        discard_q <= redirect_i;
                    end
                    if (redirect_i) begin
                        pc_q <= F_sel_PC_i;
                    end
                end
                S_WAIT: begin
                    if (data_fire) begin
                        state_q   <= S_REQ;
                        discard_q <= 1'b0;
                    end else if (redirect_i) begin
                        discard_q <= 1'b1;
                    end
                    // A dropped response leaves pc_q alone unless redirected
                    if (capture || redirect_i) begin
                        pc_q <= F_sel_PC_i;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output register and skid buffer toward decode
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            d_valid_q    <= 1'b0;
            d_pc_q       <= '0;
            d_instr_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else if (flush) begin
            d_valid_q    <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (skid_valid_q) begin
            // No request is issued while the skid is full, so no capture here
            if (out_free) begin
                d_valid_q    <= 1'b1;
                d_pc_q       <= skid_pc_q;
                d_instr_q    <= skid_instr_q;
                skid_valid_q <= 1'b0;
            end
        end else if (capture) begin
            if (out_free) begin
                d_valid_q <= 1'b1;
                d_pc_q    <= req_pc_q;
                d_instr_q <= instr_rdata_i;
            end else begin
                skid_valid_q <= 1'b1;
                skid_pc_q    <= req_pc_q;
                skid_instr_q <= instr_rdata_i;
            end
        end else if (D_allowin_i) begin
            d_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed vectors for if_fetch; table for reset and streaming,
// hand-written sequences for stall, redirect and reset-during-wait cases.
module tb_if_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] f_sel;
    logic        redirect;
    logic [31:0] f_pc;
    logic        req;
    logic [31:0] addr;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        allowin;
    logic        d_valid;
    logic [31:0] d_pc;
    logic [31:0] d_instr;

    logic        follow;
    logic [31:0] sel_ovr;

    int passed = 0;
    int total  = 0;

    assign f_sel = follow ? f_pc : sel_ovr;

    if_fetch #(
        .PC_WIDTH(32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .F_sel_PC_i     (f_sel),
        .redirect_i     (redirect),
        .F_PC_o         (f_pc),
        .instr_req_o    (req),
        .instr_addr_o   (addr),
        .instr_addr_ok_i(addr_ok),
        .instr_data_ok_i(data_ok),
        .instr_rdata_i  (rdata),
        .D_allowin_i    (allowin),
        .D_valid_o      (d_valid),
        .D_PC_o         (d_pc),
        .D_instr_o      (d_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        aok;
        logic        dok;
        logic        allow;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_dv;
        logic [31:0] e_dpc;
        logic [31:0] e_di;
        logic [31:0] e_fpc;
        logic        dchk;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle's inputs after the falling edge, then check outputs
    task automatic step(input string tag, input logic rst, input logic aok, input logic dok,
                        input logic allow, input logic redir, input logic fol,
                        input logic [31:0] sel, input logic [31:0] rd,
                        input logic e_req, input logic [31:0] e_addr, input logic e_dv,
                        input logic [31:0] e_dpc, input logic [31:0] e_di, input logic dchk);
        @(negedge clk);
        rst_n    = rst;
        addr_ok  = aok;
        data_ok  = dok;
        allowin  = allow;
        redirect = redir;
        follow   = fol;
        sel_ovr  = sel;
        rdata    = rd;
        #1;
        check({tag, ".req"}, {31'd0, req}, {31'd0, e_req});
        if (e_req) check({tag, ".addr"}, addr, e_addr);
        check({tag, ".dvalid"}, {31'd0, d_valid}, {31'd0, e_dv});
        if (e_dv || dchk) begin
            check({tag, ".dpc"}, d_pc, e_dpc);
            check({tag, ".dinstr"}, d_instr, e_di);
        end
    endtask

    task automatic hs(input string tag, input logic aok, input logic dok, input logic allow,
                      input logic redir, input logic [31:0] sel, input logic [31:0] rd,
                      input logic e_req, input logic [31:0] e_addr, input logic e_dv,
                      input logic [31:0] e_dpc, input logic [31:0] e_di);
        step(tag, 1'b1, aok, dok, allow, redir, ~redir, sel, rd,
             e_req, e_addr, e_dv, e_dpc, e_di, 1'b0);
    endtask

    initial begin
        rst_n    = 1'b0;
        addr_ok  = 1'b0;
        data_ok  = 1'b0;
        allowin  = 1'b1;
        redirect = 1'b0;
        follow   = 1'b1;
        sel_ovr  = '0;
        rdata    = '0;

        //            rst   aok   dok   allow rdata       req   addr   dv    dpc    di     fpc    dchk
        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b1};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0,      1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD,   1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h11,     1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h4, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0,      1'b1, 32'h4, 1'b1, 32'h0, 32'h11, 32'h8, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h22,     1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h8, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0,      1'b1, 32'h8, 1'b1, 32'h4, 32'h22, 32'hC, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h33,     1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'hC, 1'b0};

        // First cycle: outputs undefined before the first reset edge
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            step($sformatf("row%0d", i), tbl[i].rst, tbl[i].aok, tbl[i].dok, tbl[i].allow,
                 1'b0, 1'b1, 32'h0, tbl[i].rdata, tbl[i].e_req, tbl[i].e_addr,
                 tbl[i].e_dv, tbl[i].e_dpc, tbl[i].e_di, tbl[i].dchk);
            check($sformatf("row%0d.fpc", i), f_pc, tbl[i].e_fpc);
        end

        // Decode stalls six cycles: output register then skid fill, requests stop
        hs("stall1", 1, 1, 0, 0, 0, 32'h0,  1, 32'hC, 1, 32'h8, 32'h33);
        hs("stall2", 1, 1, 0, 0, 0, 32'h44, 0, 32'h0, 1, 32'h8, 32'h33);
        for (int k = 3; k <= 6; k++)
            hs($sformatf("stall%0d", k), 1, 1, 0, 0, 0, 32'h0, 0, 32'h0, 1, 32'h8, 32'h33);
        hs("stall7", 1, 1, 1, 0, 0, 32'h0,  0, 32'h0,  1, 32'h8,  32'h33);
        hs("drain1", 1, 1, 1, 0, 0, 32'h0,  1, 32'h10, 1, 32'hC,  32'h44);
        hs("drain2", 1, 1, 1, 0, 0, 32'h55, 0, 32'h0,  0, 32'h0,  32'h0);
        hs("drain3", 1, 1, 1, 0, 0, 32'h0,  1, 32'h14, 1, 32'h10, 32'h55);

        // Redirect in WAIT, response three cycles later is dropped
        hs("rdw0", 0, 0, 1, 1, 32'h100, 32'h0,  0, 32'h0, 0, 32'h0, 32'h0);
        hs("rdw1", 0, 0, 1, 0, 32'h0,   32'h0,  0, 32'h0, 0, 32'h0, 32'h0);
        check("rdw1.fpc", f_pc, 32'h104);
        hs("rdw2", 0, 0, 1, 0, 32'h0,   32'h0,  0, 32'h0, 0, 32'h0, 32'h0);
        hs("rdw3", 0, 1, 1, 0, 32'h0,   32'h66, 0, 32'h0, 0, 32'h0, 32'h0);

        // Redirect coinciding with addr_ok
        hs("rdaok0", 1, 0, 1, 1, 32'h200, 32'h0,  1, 32'h100, 0, 32'h0, 32'h0);
        hs("rdaok1", 0, 1, 1, 0, 32'h0,   32'h77, 0, 32'h0,   0, 32'h0, 32'h0);
        hs("rdaok2", 1, 0, 1, 0, 32'h0,   32'h0,  1, 32'h200, 0, 32'h0, 32'h0);
        check("rdaok2.fpc", f_pc, 32'h204);

        // Redirect coinciding with data_ok
        hs("rdok0", 0, 1, 1, 1, 32'h300, 32'h88, 0, 32'h0,   0, 32'h0,   32'h0);
        hs("rdok1", 1, 0, 1, 0, 32'h0,   32'h0,  1, 32'h300, 0, 32'h0,   32'h0);
        hs("rdok2", 0, 1, 1, 0, 32'h0,   32'h99, 0, 32'h0,   0, 32'h0,   32'h0);
        hs("rdok3", 1, 0, 0, 0, 32'h0,   32'h0,  1, 32'h304, 1, 32'h300, 32'h99);

        // Redirect flushes both output register and skid, then redirect in REQ
        hs("rdclr0", 0, 1, 0, 0, 32'h0,         32'hAA, 0, 32'h0,   1, 32'h300, 32'h99);
        hs("rdclr1", 1, 0, 0, 1, 32'h400,       32'h0,  0, 32'h0,   1, 32'h300, 32'h99);
        hs("rdclr2", 0, 0, 1, 1, 32'hFFFF_FFFC, 32'h0,  1, 32'h400, 0, 32'h0,   32'h0);
        hs("rdclr3", 0, 0, 0, 0, 32'h0,         32'h0,  1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
        check("wrap.fpc", f_pc, 32'h0);

        // One-cycle reset while in WAIT, then stray data_ok responses
        hs("rstw0", 1, 0, 1, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0);
        step("rstw1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0,
             1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
        step("rstw2", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'hBB,
             1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        hs("rstw3", 0, 1, 1, 0, 32'h0, 32'hCC, 1, 32'h0, 0, 32'h0, 32'h0);
        hs("rstw4", 0, 0, 1, 0, 32'h0, 32'h0,  1, 32'h0, 0, 32'h0, 32'h0);
        check("rstw4.fpc", f_pc, 32'h4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
